// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the memory-side arbitration logic.
// Owner encoding and reset defaults are common to the arbiter and its round-robin picker.
package mips_mem_pkg;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_INSTR = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int unsigned ADDR_W_DEF = 18;
    localparam int unsigned DATA_W_DEF = 16;

    // Every read-data bit is filled with this value when the watchdog aborts a transaction.
    localparam logic TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/sram_rr_arb2.sv
// Combinational two-way round-robin pick between the data and instruction requesters.
// When both sides are eligible, the side that did not win last time gets the grant.
module sram_rr_arb2
    import mips_mem_pkg::*;
(
    input  logic d_elig,
    input  logic i_elig,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = d_elig | i_elig;
        grant_owner = OWN_DATA;
        if (d_elig && i_elig) begin
            grant_owner = (last_owner == OWN_DATA) ? OWN_INSTR : OWN_DATA;
        end else if (i_elig) begin
            grant_owner = OWN_INSTR;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller between the data and instruction-fetch sides.
// Latches the winning command, holds it until ready, and aborts hung transactions.
module sram_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              sram_req,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_write_data,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_read_data,
    input  logic              sram_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned    CntW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] WdLast =
        CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [CntW-1:0]     wd_cnt_q, wd_cnt_d;
    logic                d_ack_q, d_ack_d;
    logic                i_ack_q, i_ack_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic                timeout_q, timeout_d;

    logic grant_valid;
    logic grant_owner;
    logic wd_expired;

    // A side being acked this cycle is masked so its stale level request is not regranted.
    sram_rr_arb2 u_arb (
        .d_elig      (d_req & ~d_ack_q),
        .i_elig      (i_req & ~i_ack_q),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WdLast);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        wd_cnt_d     = wd_cnt_q;
        d_ack_d      = 1'b0;
        i_ack_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        i_rdata_d    = i_rdata_q;
        timeout_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d      = owner_e'(grant_owner);
                    last_owner_d = owner_e'(grant_owner);
                    if (owner_e'(grant_owner) == OWN_DATA) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end else begin
                        addr_d  = i_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                    wd_cnt_d = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wd_cnt_q != '1) begin
                    wd_cnt_d = wd_cnt_q + CntW'(1);
                end
                // Ready takes priority over a watchdog expiry in the same cycle.
                if (sram_ready) begin
                    state_d = ST_IDLE;
                    we_d    = 1'b0;
                    if (owner_q == OWN_DATA) begin
                        d_ack_d = 1'b1;
                        if (!we_q) d_rdata_d = sram_read_data;
                    end else begin
                        i_ack_d = 1'b1;
                        if (!we_q) i_rdata_d = sram_read_data;
                    end
                end else if (wd_expired) begin
                    state_d   = ST_IDLE;
                    we_d      = 1'b0;
                    timeout_d = 1'b1;
                    if (owner_q == OWN_DATA) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = {DATA_W{TIMEOUT_FILL}};
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = {DATA_W{TIMEOUT_FILL}};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_DATA;
            last_owner_q <= OWN_INSTR;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            wd_cnt_q     <= '0;
            d_ack_q      <= 1'b0;
            i_ack_q      <= 1'b0;
            d_rdata_q    <= '0;
            i_rdata_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            wd_cnt_q     <= wd_cnt_d;
            d_ack_q      <= d_ack_d;
            i_ack_q      <= i_ack_d;
            d_rdata_q    <= d_rdata_d;
            i_rdata_q    <= i_rdata_d;
            timeout_q    <= timeout_d;
        end
    end

    assign busy            = (state_q == ST_BUSY);
    assign sram_req        = busy;
    assign sram_address    = addr_q;
    assign sram_write_data = wdata_q;
    assign sram_we         = we_q;
    assign d_ack           = d_ack_q;
    assign i_ack           = i_ack_q;
    assign d_rdata         = d_rdata_q;
    assign i_rdata         = i_rdata_q;
    assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with an 8-cycle watchdog.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req, d_we, d_ack, i_req, i_ack;
    logic [17:0] d_addr, i_addr, sram_address;
    logic [15:0] d_wdata, d_rdata, i_rdata, sram_write_data, sram_read_data;
    logic        sram_req, sram_we, sram_ready, busy, timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W         (18),
        .DATA_W         (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_ack           (d_ack),
        .d_rdata         (d_rdata),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .i_ack           (i_ack),
        .i_rdata         (i_rdata),
        .sram_req        (sram_req),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_we         (sram_we),
        .sram_read_data  (sram_read_data),
        .sram_ready      (sram_ready),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [17:0] c_addr [4];
    logic [15:0] c_data [4];
    logic        c_isd  [4];

    initial begin
        c_addr = '{18'h00100, 18'h00200, 18'h00100, 18'h00200};
        c_data = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        c_isd  = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 18'h00123; d_wdata = '0;
        i_req = 1'b0; i_addr = '0; sram_read_data = '0; sram_ready = 1'b0;
        step(); step(); step();
        check("rst_sram_req", 32'(sram_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({d_ack, i_ack}), 32'd0);
        check("rst_rdata", 32'({d_rdata, i_rdata}), 32'd0);

        // Release reset with d_req held: data side is granted on the next edge.
        rst = 1'b1;
        step();
        check("rd_grant_req", 32'(sram_req), 32'd1);
        check("rd_addr", 32'(sram_address), 32'h00123);
        check("rd_we", 32'(sram_we), 32'd0);
        step(); step();
        check("rd_still_busy", 32'(busy), 32'd1);
        sram_ready = 1'b1; sram_read_data = 16'hBEEF;
        step();
        check("rd_ack", 32'({d_ack, i_ack}), 32'b10);
        check("rd_rdata", 32'(d_rdata), 32'hBEEF);
        check("rd_idle", 32'(busy), 32'd0);
        d_req = 1'b0; sram_ready = 1'b0; sram_read_data = 16'h0000;
        step();
        check("rd_ack_pulse", 32'(d_ack), 32'd0);
        check("rd_rdata_held", 32'(d_rdata), 32'hBEEF);

        // Write: rdata must not change.
        d_req = 1'b1; d_we = 1'b1; d_addr = 18'h00040; d_wdata = 16'h1234;
        step();
        check("wr_we", 32'(sram_we), 32'd1);
        check("wr_addr", 32'(sram_address), 32'h00040);
        check("wr_wdata", 32'(sram_write_data), 32'h1234);
        step();
        sram_ready = 1'b1; sram_read_data = 16'h5555;
        step();
        check("wr_ack", 32'(d_ack), 32'd1);
        check("wr_rdata_kept", 32'(d_rdata), 32'hBEEF);
        check("wr_we_idle", 32'(sram_we), 32'd0);
        d_req = 1'b0; d_we = 1'b0; sram_ready = 1'b0;
        step();
        check("wr_ack_pulse", 32'(d_ack), 32'd0);

        // Instruction read, leaves last owner = INSTR.
        i_req = 1'b1; i_addr = 18'h00321;
        step();
        check("if_addr", 32'(sram_address), 32'h00321);
        sram_ready = 1'b1; sram_read_data = 16'hCAFE;
        step();
        check("if_ack", 32'({d_ack, i_ack}), 32'b01);
        check("if_rdata", 32'(i_rdata), 32'hCAFE);
        i_req = 1'b0; sram_ready = 1'b0;
        step();

        // Contention: both held, expect D, I, D, I.
        d_req = 1'b1; d_addr = 18'h00100; i_req = 1'b1; i_addr = 18'h00200;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("ct%0d_addr", k), 32'(sram_address), 32'(c_addr[k]));
            check($sformatf("ct%0d_busy", k), 32'(busy), 32'd1);
            sram_ready = 1'b1; sram_read_data = c_data[k];
            step();
            sram_ready = 1'b0;
            check($sformatf("ct%0d_acks", k), 32'({d_ack, i_ack}),
                  c_isd[k] ? 32'b10 : 32'b01);
            check($sformatf("ct%0d_rdata", k), 32'(c_isd[k] ? d_rdata : i_rdata),
                  32'(c_data[k]));
        end
        d_req = 1'b0; i_req = 1'b0;
        step();
        check("ct_quiet", 32'({d_ack, i_ack, busy}), 32'd0);

        // Watchdog: ready never comes.
        i_req = 1'b1; i_addr = 18'h003FF;
        step();
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("to_wait%0d", k), 32'({busy, timeout_err, i_ack}), 32'b100);
        end
        step();
        check("to_ack", 32'({i_ack, timeout_err, busy}), 32'b110);
        check("to_rdata", 32'(i_rdata), 32'hFFFF);
        i_req = 1'b0;
        step();
        check("to_pulse", 32'({i_ack, timeout_err, busy}), 32'b000);

        // Reset mid-transaction.
        d_req = 1'b1; d_addr = 18'h000AA;
        step(); step();
        check("mr_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mr_drop", 32'({sram_req, busy}), 32'd0);
        check("mr_rdata_clr", 32'(d_rdata), 32'h0000);
        sram_ready = 1'b1; sram_read_data = 16'h7777;
        step();
        check("mr_no_ack", 32'({d_ack, i_ack}), 32'd0);
        d_req = 1'b0; sram_ready = 1'b0; rst = 1'b1;
        step();
        check("mr_idle", 32'({busy, d_ack, i_ack}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
